// File: rtl/pc_context_sched.sv
// Multi-context program counter with preemptive round-robin time slicing and I/O stall handling.
// Optional macro QUANTUM_PROG_EN adds a run-time programmable quantum (quantum_we/quantum_in).
module pc_context_sched #(
    parameter int          WIDTH      = 32,
    parameter int          NUM_CTX    = 4,
    parameter int          CTX_W      = $clog2(NUM_CTX),
    parameter int          QUANTUM    = 11,
    parameter logic [31:0] CTX_STRIDE = 32'h0000_0400
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               input_flag,
    input  logic               output_flag,
    input  logic               insert,
    input  logic [WIDTH-1:0]   addressIn,
    input  logic               inProgram,
    input  logic [NUM_CTX-1:0] ctx_active,
`ifdef QUANTUM_PROG_EN
    input  logic               quantum_we,
    input  logic [7:0]         quantum_in,
`endif
    output logic [WIDTH-1:0]   addressOut,
    output logic [CTX_W-1:0]   ctx_id,
    output logic               ContextChange,
    output logic [7:0]         instcount
);

    typedef enum logic [1:0] {RUN, IO_WAIT, SWITCH} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   addr_q;
    logic [CTX_W-1:0]   ctx_q;
    logic               cc_q;
    logic [7:0]         cnt_q;
    logic               last_ins_q;
    logic               pend_q;

    logic               stall;
    logic [7:0]         cnt_inc;
    logic [7:0]         quantum_last;
    logic [CTX_W-1:0]   next_ctx;
    logic               found;
    logic [CTX_W:0]     idx;
    logic [WIDTH-1:0]   saved_pc [NUM_CTX];

    assign stall   = input_flag | output_flag;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

`ifdef QUANTUM_PROG_EN
    logic [7:0] quantum_reg;
    logic [7:0] slice_quantum_q;

    // A newly written quantum only applies once the next slice begins.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            quantum_reg     <= 8'(QUANTUM);
            slice_quantum_q <= 8'(QUANTUM);
        end else begin
            if (quantum_we)
                quantum_reg <= (quantum_in == 8'd0) ? 8'd1 : quantum_in;
            if (state_q == SWITCH || (state_q == RUN && !stall && !inProgram))
                slice_quantum_q <= quantum_reg;
        end
    end
    assign quantum_last = slice_quantum_q - 8'd1;
`else
    assign quantum_last = 8'(QUANTUM - 1);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTX; gi++) begin : g_ctx
            localparam logic [WIDTH-1:0] RST_PC = WIDTH'(64'(gi) * 64'(CTX_STRIDE));
            logic [WIDTH-1:0] pc_q;
            always_ff @(posedge CLK or negedge reset) begin
                if (!reset)
                    pc_q <= RST_PC;
                else if (state_q == SWITCH && ctx_q == CTX_W'(gi))
                    pc_q <= addressIn;
            end
            assign saved_pc[gi] = pc_q;
        end
    endgenerate

    // Round-robin: first active context after the running one; itself only by wrap-around.
    always_comb begin
        next_ctx = ctx_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k < NUM_CTX; k++) begin
            idx = {1'b0, ctx_q} + (CTX_W+1)'(k);
            if (idx >= (CTX_W+1)'(NUM_CTX))
                idx = idx - (CTX_W+1)'(NUM_CTX);
            if (!found && ctx_active[idx[CTX_W-1:0]]) begin
                found    = 1'b1;
                next_ctx = idx[CTX_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            addr_q     <= '0;
            ctx_q      <= '0;
            cc_q       <= 1'b0;
            cnt_q      <= 8'd0;
            last_ins_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            cc_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (stall) begin
                        // A stall landing on the expiry cycle defers the switch until I/O ends.
                        state_q <= IO_WAIT;
                        pend_q  <= inProgram && (cnt_q >= quantum_last);
                    end else if (!inProgram) begin
                        addr_q <= addressIn;
                        cnt_q  <= 8'd0;
                        pend_q <= 1'b0;
                    end else begin
                        addr_q <= addressIn;
                        cnt_q  <= cnt_inc;
                        if (cnt_q >= quantum_last)
                            state_q <= SWITCH;
                    end
                end
                IO_WAIT: begin
                    if (stall && (insert != last_ins_q)) begin
                        addr_q     <= addressIn;
                        cnt_q      <= cnt_inc;
                        last_ins_q <= insert;
                        if (cnt_q >= quantum_last)
                            pend_q <= 1'b1;
                    end
                    if (!stall) begin
                        state_q <= (pend_q && inProgram) ? SWITCH : RUN;
                        pend_q  <= 1'b0;
                    end
                end
                SWITCH: begin
                    if (next_ctx != ctx_q) begin
                        ctx_q  <= next_ctx;
                        addr_q <= saved_pc[next_ctx];
                        cc_q   <= 1'b1;
                    end else begin
                        addr_q <= addressIn;
                    end
                    cnt_q   <= 8'd0;
                    pend_q  <= 1'b0;
                    state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign addressOut    = addr_q;
    assign ctx_id        = ctx_q;
    assign ContextChange = cc_q;
    assign instcount     = cnt_q;

endmodule

// File: tb/tb_pc_context_sched.sv
// Directed bench for pc_context_sched: slicing, round-robin, I/O stalls, kernel mode, async reset.
module tb_pc_context_sched;

    logic        CLK = 1'b0;
    logic        reset;
    logic        input_flag;
    logic        output_flag;
    logic        insert;
    logic [31:0] addressIn;
    logic        inProgram;
    logic [3:0]  ctx_active;
    logic [31:0] addressOut;
    logic [1:0]  ctx_id;
    logic        ContextChange;
    logic [7:0]  instcount;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    pc_context_sched dut (
        .CLK          (CLK),
        .reset        (reset),
        .input_flag   (input_flag),
        .output_flag  (output_flag),
        .insert       (insert),
        .addressIn    (addressIn),
        .inProgram    (inProgram),
        .ctx_active   (ctx_active),
        .addressOut   (addressOut),
        .ctx_id       (ctx_id),
        .ContextChange(ContextChange),
        .instcount    (instcount)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_addr, input logic [1:0] e_ctx,
                             input logic e_cc, input logic [7:0] e_cnt);
        chk({tag, ".addr"}, addressOut, e_addr);
        chk({tag, ".ctx"}, {30'd0, ctx_id}, {30'd0, e_ctx});
        chk({tag, ".cc"}, {31'd0, ContextChange}, {31'd0, e_cc});
        chk({tag, ".cnt"}, {24'd0, instcount}, {24'd0, e_cnt});
        $display("step %s: addr=%h ctx=%0d cc=%0b cnt=%0d", tag, addressOut, ctx_id, ContextChange, instcount);
    endtask

    // n unstalled updates addressIn = base+4k; count starts at cnt0 in context e_ctx.
    task automatic run_updates(input logic [31:0] base, input int n, input int cnt0, input logic [1:0] e_ctx);
        for (int k = 1; k <= n; k++) begin
            addressIn = base + 32'(4 * k);
            tick();
            chk_state("upd", base + 32'(4 * k), e_ctx, 1'b0, 8'(cnt0 + k));
        end
    endtask

    initial begin
        reset       = 1'b0;
        input_flag  = 1'b0;
        output_flag = 1'b0;
        insert      = 1'b0;
        addressIn   = 32'h0;
        inProgram   = 1'b0;
        ctx_active  = 4'b0101;

        tick();
        chk_state("reset", 32'h0, 2'd0, 1'b0, 8'd0);
        reset     = 1'b1;
        inProgram = 1'b1;

        // Quantum expiry: ctx0 -> ctx2 (reset PC 0x800), then back to ctx0 at 0x2C.
        run_updates(32'h0, 11, 0, 2'd0);
        tick();
        chk_state("sw0to2", 32'h800, 2'd2, 1'b1, 8'd0);
        run_updates(32'h800, 11, 0, 2'd2);
        tick();
        chk_state("sw2to0", 32'h2C, 2'd0, 1'b1, 8'd0);

        // Only the running context active: no switch, PC tracks addressIn.
        ctx_active = 4'b0001;
        run_updates(32'h2C, 11, 0, 2'd0);
        addressIn = 32'h5C;
        tick();
        chk_state("noswitch", 32'h5C, 2'd0, 1'b0, 8'd0);

        // Input stall at count 5, three insert toggles.
        run_updates(32'h5C, 5, 0, 2'd0);
        input_flag = 1'b1;
        addressIn  = 32'h74;
        tick();
        chk_state("io_enter", 32'h70, 2'd0, 1'b0, 8'd5);
        tick();
        chk_state("io_hold0", 32'h70, 2'd0, 1'b0, 8'd5);
        insert = 1'b1;
        tick();
        chk_state("io_tog1", 32'h74, 2'd0, 1'b0, 8'd6);
        addressIn = 32'h78;
        tick();
        chk_state("io_hold1", 32'h74, 2'd0, 1'b0, 8'd6);
        insert = 1'b0;
        tick();
        chk_state("io_tog2", 32'h78, 2'd0, 1'b0, 8'd7);
        addressIn = 32'h7C;
        insert    = 1'b1;
        tick();
        chk_state("io_tog3", 32'h7C, 2'd0, 1'b0, 8'd8);
        input_flag = 1'b0;
        addressIn  = 32'h80;
        tick();
        chk_state("io_exit", 32'h7C, 2'd0, 1'b0, 8'd8);

        // Output stall rising on the expiry cycle defers the switch.
        ctx_active = 4'b0101;
        run_updates(32'h7C, 2, 8, 2'd0);
        output_flag = 1'b1;
        addressIn   = 32'h88;
        tick();
        chk_state("defer0", 32'h84, 2'd0, 1'b0, 8'd10);
        tick();
        chk_state("defer1", 32'h84, 2'd0, 1'b0, 8'd10);
        output_flag = 1'b0;
        tick();
        chk_state("defer2", 32'h84, 2'd0, 1'b0, 8'd10);
        tick();
        chk_state("defer_sw", 32'h82C, 2'd2, 1'b1, 8'd0);

        // Kernel mode: no counting, no preemption.
        inProgram = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            addressIn = 32'h900 + 32'(4 * k);
            tick();
            chk_state("kernel", 32'h900 + 32'(4 * k), 2'd2, 1'b0, 8'd0);
        end

        // Reset asserted while in the SWITCH cycle.
        inProgram = 1'b1;
        run_updates(32'h900, 11, 0, 2'd2);
        reset = 1'b0;
        #1;
        chk_state("rst_mid", 32'h0, 2'd0, 1'b0, 8'd0);
        tick();
        reset = 1'b1;
        run_updates(32'h0, 11, 0, 2'd0);
        tick();
        chk_state("rst_saved", 32'h800, 2'd2, 1'b1, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_context_sched.md
Name: pc_context_sched

Overview:
- Parametrised multi-context program counter with preemptive round-robin time slicing. It replaces the single-context PC.
- Holds one saved PC per hardware context. It counts instructions retired in the running context and, when the quantum expires, saves the next PC and resumes the next active context.
- Sits between next-PC logic (addressIn) and instruction fetch (addressOut). Honours I/O stalls using the insert-toggle protocol.

Parameters:
- WIDTH, 32, address width.
- NUM_CTX, 4, number of hardware contexts (min 2).
- CTX_W, $clog2(NUM_CTX), context index width.
- QUANTUM, 11, accepted instructions per time slice before preemption (min 1).
- CTX_STRIDE, 32'h0000_0400, reset PC of context i = i*CTX_STRIDE (truncated to WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_flag  in  1  input I/O in progress (stall).
- output_flag  in  1  output I/O in progress (stall).
- insert  in  1  toggle; each change while stalled advances the PC once.
- addressIn  in  WIDTH  next PC from PC-update logic.
- inProgram  in  1  1 = user program running; 0 = kernel/idle, no preemption.
- ctx_active  in  NUM_CTX  bit i = context i holds a runnable program.
- addressOut  out  WIDTH  current fetch PC.
- ctx_id  out  CTX_W  running context index.
- ContextChange  out  1  one-cycle pulse on the cycle a switch commits.
- instcount  out  8  instructions counted in the current slice (debug).

Behaviour:
- Reset (reset=0, asynchronous):
  - addressOut=0, ctx_id=0, ContextChange=0, instcount=0, last_insert=0, state=RUN.
  - saved_pc[i]=i*CTX_STRIDE.
- Release is synchronous to CLK. Reset asserted mid-switch or mid-I/O aborts the switch or I/O with no partial save.
- stall = input_flag | output_flag.
- States:
  - RUN:
    - stall=0: addressOut<=addressIn; instcount<=instcount+1.
    - If inProgram=0: instcount<=0 instead and there is no preemption.
    - If stall=0, inProgram=1 and instcount==QUANTUM-1: the update still happens and the next state is SWITCH.
    - stall=1: go to IO_WAIT in the same cycle, with no PC update that cycle.
  - IO_WAIT:
    - On insert!=last_insert: addressOut<=addressIn; instcount<=instcount+1; last_insert<=insert.
    - insert unchanged: hold.
    - stall=0: return to RUN.
    - If instcount reached QUANTUM while in IO_WAIT, the switch is deferred and taken on the first stall=0 cycle (RUN→SWITCH without a further update).
    - I/O always has priority over preemption.
  - SWITCH (exactly one cycle):
    - saved_pc[ctx_id]<=addressIn.
    - next = first i with ctx_active[i]=1, searching ctx_id+1 … wrapping to ctx_id.
    - If next≠ctx_id: ctx_id<=next; addressOut<=saved_pc[next]; ContextChange<=1.
    - If no other context is active: ctx_id unchanged; addressOut<=addressIn; ContextChange<=0.
    - instcount<=0 in both cases; return to RUN.
- Latency: addressIn→addressOut is 1 cycle. Quantum expiry→new PC on addressOut is 1 cycle (the SWITCH cycle).
- ContextChange is 0 in every cycle other than the one after a committed switch.
- ctx_active is sampled only in SWITCH. Deasserting the running context's bit does not preempt early.
- ctx_active all zero: no switch; the current context continues.
- instcount saturates at 255 and never wraps.
- Simultaneous stall rise and quantum expiry: stall wins; no update that cycle; the switch is deferred.

Optional Feature:
- Macro QUANTUM_PROG_EN.
- When defined:
  - Adds ports quantum_we (in, 1) and quantum_in (in, 8), plus an 8-bit register quantum_reg that resets to QUANTUM.
  - quantum_we=1 loads quantum_in on the next edge and takes effect from the next slice.
  - quantum_in=0 is treated as 1.
  - Expiry compare uses quantum_reg.
- When undefined: the ports are absent and expiry uses the QUANTUM parameter only.

Test Plan:
- Reset → addressOut=0, ctx_id=0, instcount=0, ContextChange=0. After release, addressIn=4,8,12… appears on addressOut one cycle later.
- ctx_active=4'b0101, inProgram=1, 11 unstalled updates ending with addressIn=0x2C:
  - ctx_id=2, addressOut=0x800, ContextChange pulses 1 cycle.
  - A later expiry back to ctx 0 yields addressOut=0x2C.
- ctx_active=4'b0001 → at expiry ctx_id stays 0, ContextChange=0, addressOut tracks addressIn, instcount returns to 0.
- input_flag=1 at instcount=5 with three insert toggles → exactly 3 PC updates, instcount=8. Unchanged insert holds addressOut.
- output_flag rises on the expiry cycle → no switch while stalled. The switch occurs on the first cycle after output_flag=0.
- inProgram=0 for 20 cycles → instcount stays 0 and no ContextChange. Reset pulse mid-SWITCH → all outputs at reset values.
